// File: rtl/next_line_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : next_line_predictor_pkg
// Purpose  : Shared entry/info types and counter constants for the NLP.
// Revision : 1.0
// ============================================================================
package next_line_predictor_pkg;

    localparam logic [1:0] CTR_INIT = 2'b10;
    localparam logic [1:0] CTR_MAX  = 2'b11;
    localparam logic [1:0] CTR_MIN  = 2'b00;

    // Tag field is sized for the widest possible tag; narrower tags are zero-extended.
    localparam int NLP_TAG_MAX = 30;

    typedef struct packed {
        logic                   valid;
        logic [NLP_TAG_MAX-1:0] tag;
        logic [31:0]            target;
        logic [1:0]             ctr;
    } nlp_entry_t;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] target;
    } nlp_info_t;

endpackage
`default_nettype wire

// File: rtl/nlp_sat_ctr.sv
`default_nettype none
// ============================================================================
// Module   : nlp_sat_ctr
// Purpose  : Pure 2-bit saturating up/down counter next-value function.
// Revision : 1.0
// ============================================================================
module nlp_sat_ctr
    import next_line_predictor_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_inc,
    output logic [1:0] o_ctr_next
);

    always_comb begin
        o_ctr_next = i_ctr;
        if (i_inc) begin
            if (i_ctr != CTR_MAX) o_ctr_next = i_ctr + 2'd1;
        end else begin
            if (i_ctr != CTR_MIN) o_ctr_next = i_ctr - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/next_line_predictor.sv
`default_nettype none
// ============================================================================
// Module   : next_line_predictor
// Purpose  : Direct-mapped tagged next-line predictor, two same-cycle lookup
//            ports (pc, pc+4) and one training port. Optional macro
//            NLP_BYPASS_EN forwards a same-cycle update to the lookups.
// Revision : 1.0
// ============================================================================
module next_line_predictor
    import next_line_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        nlp0_valid,
    output logic        nlp0_taken,
    output logic [31:0] nlp0_target,
    output logic        nlp1_valid,
    output logic        nlp1_taken,
    output logic [31:0] nlp1_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_kill
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_LSB = IDX_W + 2;

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] addr);
        return addr[2 +: IDX_W];
    endfunction

    function automatic logic [NLP_TAG_MAX-1:0] tag_of(input logic [31:0] addr);
        logic [NLP_TAG_MAX-1:0] t;
        t = '0;
        t[TAG_W-1:0] = addr[TAG_LSB +: TAG_W];
        return t;
    endfunction

    function automatic nlp_info_t lookup(input nlp_entry_t e,
                                         input logic [NLP_TAG_MAX-1:0] tag);
        nlp_info_t info;
        info.valid  = e.valid && (e.tag == tag);
        info.taken  = info.valid && e.ctr[1];
        info.target = info.valid ? e.target : 32'd0;
        return info;
    endfunction

    nlp_entry_t table_q [ENTRIES];
    nlp_entry_t table_d [ENTRIES];

    logic [31:0]      w_pc1;
    logic [IDX_W-1:0] w_idx0, w_idx1, w_upd_idx;
    nlp_entry_t       w_old, w_upd_entry, w_ent0, w_ent1;
    logic             w_upd_hit, w_wr_en;
    logic [1:0]       w_ctr_next;
    nlp_info_t        w_info0, w_info1;
    logic             unused_bits;

    assign w_pc1       = pc + 32'd4;
    assign w_idx0      = idx_of(pc);
    assign w_idx1      = idx_of(w_pc1);
    assign w_upd_idx   = idx_of(upd_pc);
    assign w_old       = table_q[w_upd_idx];
    assign w_upd_hit   = w_old.valid && (w_old.tag == tag_of(upd_pc));
    assign unused_bits = ^{pc, w_pc1, upd_pc};

    nlp_sat_ctr u_sat_ctr (
        .i_ctr      (w_old.ctr),
        .i_inc      (upd_taken),
        .o_ctr_next (w_ctr_next)
    );

    // Post-update view of the indexed entry; equals w_old when nothing is written.
    always_comb begin
        w_upd_entry = w_old;
        w_wr_en     = 1'b0;
        if (w_upd_hit) begin
            w_wr_en = 1'b1;
            if (upd_kill) begin
                w_upd_entry.valid = 1'b0;
            end else begin
                w_upd_entry.ctr = w_ctr_next;
                if (upd_taken) w_upd_entry.target = upd_target;
            end
        end else if (upd_taken && !upd_kill) begin
            w_wr_en            = 1'b1;
            w_upd_entry.valid  = 1'b1;
            w_upd_entry.tag    = tag_of(upd_pc);
            w_upd_entry.target = upd_target;
            w_upd_entry.ctr    = CTR_INIT;
        end
    end

    always_comb begin
        table_d = table_q;
        if (upd_valid && w_wr_en) table_d[w_upd_idx] = w_upd_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
                table_q[i].ctr   <= CTR_MIN;
            end
        end else begin
            table_q <= table_d;
        end
    end

    always_comb begin
        w_ent0 = table_q[w_idx0];
        w_ent1 = table_q[w_idx1];
`ifdef NLP_BYPASS_EN
        if (upd_valid && (w_upd_idx == w_idx0)) w_ent0 = w_upd_entry;
        if (upd_valid && (w_upd_idx == w_idx1)) w_ent1 = w_upd_entry;
`endif
    end

    assign w_info0 = lookup(w_ent0, tag_of(pc));
    assign w_info1 = lookup(w_ent1, tag_of(w_pc1));

    assign nlp0_valid  = rst ? 1'b0  : w_info0.valid;
    assign nlp0_taken  = rst ? 1'b0  : w_info0.taken;
    assign nlp0_target = rst ? 32'd0 : w_info0.target;
    assign nlp1_valid  = rst ? 1'b0  : w_info1.valid;
    assign nlp1_taken  = rst ? 1'b0  : w_info1.taken;
    assign nlp1_target = rst ? 32'd0 : w_info1.target;

endmodule
`default_nettype wire
